// File: rtl/drum_pkg.sv
// Shared types and default geometry for the drum memory controller.
package drum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        DONE = 2'd2
    } drum_state_e;

    localparam int DRUM_ADDR_W        = 11;
    localparam int DRUM_DATA_W        = 31;
    localparam int DRUM_SECTOR_CYCLES = 4;

    // One full revolution, in clock cycles.
    localparam int REV_CYCLES = (2 ** DRUM_ADDR_W) * DRUM_SECTOR_CYCLES;

endpackage

// File: rtl/drum_rotor.sv
// Free-running drum rotor: cycle-within-sector phase and word position under the head.
module drum_rotor #(
    parameter int ADDR_W        = 11,
    parameter int SECTOR_CYCLES = 4,
    parameter int PHASE_W       = $clog2(SECTOR_CYCLES)
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  drum_pos,
    output logic [PHASE_W-1:0] drum_phase,
    output logic               sector_last
);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SECTOR_CYCLES - 1);

    logic [ADDR_W-1:0]  pos_q,   pos_d;
    logic [PHASE_W-1:0] phase_q, phase_d;

    always_comb begin
        phase_d = phase_q + 1'b1;
        pos_d   = pos_q;
        if (phase_q == PHASE_LAST) begin
            phase_d = '0;
            pos_d   = pos_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q   <= '0;
            phase_q <= '0;
        end else begin
            pos_q   <= pos_d;
            phase_q <= phase_d;
        end
    end

    assign drum_pos    = pos_q;
    assign drum_phase  = phase_q;
    assign sector_last = (phase_q == PHASE_LAST);

endmodule

// File: rtl/drum_mem_ctrl.sv
// Magnetic-drum main memory: request latch, rotational-latency seek, one-cycle finish pulse.
// Build option DRUM_FAST_EN: SEEK matches immediately, bypassing rotor alignment.
//
// state | meaning
// IDLE  | waiting for read_enable/write_enable
// SEEK  | request latched, waiting for the word to pass under the head
// DONE  | access complete, mem_finish high for this one cycle
module drum_mem_ctrl
    import drum_pkg::*;
#(
    parameter int ADDR_W        = DRUM_ADDR_W,
    parameter int DATA_W        = DRUM_DATA_W,
    parameter int SECTOR_CYCLES = DRUM_SECTOR_CYCLES
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             read_enable,
    input  logic                             write_enable,
    input  logic [ADDR_W-1:0]                addr,
    input  logic [DATA_W-1:0]                write_data,
    output logic [DATA_W-1:0]                read_data,
    output logic                             mem_finish,
    output logic                             busy,
    output logic [ADDR_W-1:0]                drum_pos,
    output logic [$clog2(SECTOR_CYCLES)-1:0] drum_phase
);

    localparam int WORDS = 2 ** ADDR_W;

    drum_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              wr_q,    wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q;
    logic              finish_q;
    logic              sector_last;
    logic              seek_hit;
    logic              do_write;
    logic              do_read;

    logic [DATA_W-1:0] mem_q [WORDS];

    drum_rotor #(
        .ADDR_W        (ADDR_W),
        .SECTOR_CYCLES (SECTOR_CYCLES)
    ) u_rotor (
        .clk         (clk),
        .reset       (reset),
        .drum_pos    (drum_pos),
        .drum_phase  (drum_phase),
        .sector_last (sector_last)
    );

`ifdef DRUM_FAST_EN
    assign seek_hit = 1'b1;
`else
    // The head is over the word on the last cycle of its sector.
    assign seek_hit = (drum_pos == addr_q) && sector_last;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        do_write = 1'b0;
        do_read  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (read_enable || write_enable) begin
                    addr_d  = addr;
                    wr_d    = write_enable;
                    wdata_d = write_data;
                    state_d = SEEK;
                end
            end
            SEEK: begin
                if (seek_hit) begin
                    do_write = wr_q;
                    do_read  = !wr_q;
                    state_d  = DONE;
                end
            end
            // Enables here still belong to the request just finished.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            finish_q <= do_write || do_read;
            if (do_read) begin
                rdata_q <= mem_q[addr_q];
            end
        end
    end

    // Array is not reset; a reset coinciding with the match cycle aborts the store.
    always_ff @(posedge clk) begin
        if (!reset && do_write) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign read_data  = rdata_q;
    assign mem_finish = finish_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_drum_mem_ctrl.sv
// Directed bench for drum_mem_ctrl with ADDR_W=4, SECTOR_CYCLES=2 (32-cycle revolution).
module tb_drum_mem_ctrl;

    localparam int AW = 4;
    localparam int DW = 31;
    localparam int SC = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          read_enable = 1'b0;
    logic          write_enable = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] write_data = '0;
    logic [DW-1:0] read_data;
    logic          mem_finish;
    logic          busy;
    logic [AW-1:0] drum_pos;
    logic [$clog2(SC)-1:0] drum_phase;

    int cyc;
    int n_chk;
    int n_fail;

    drum_mem_ctrl #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .SECTOR_CYCLES (SC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .addr         (addr),
        .write_data   (write_data),
        .read_data    (read_data),
        .mem_finish   (mem_finish),
        .busy         (busy),
        .drum_pos     (drum_pos),
        .drum_phase   (drum_phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    function automatic int pick(input int slow, input int fast);
`ifdef DRUM_FAST_EN
        return fast;
`else
        return slow;
`endif
    endfunction

    // Sequencer-style request: hold enables until mem_finish, drop them the cycle after.
    task automatic req(input string tag, input bit w, input bit r, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int exp_fin);
        int at;
        at           = -1;
        write_enable = w;
        read_enable  = r;
        addr         = a;
        write_data   = d;
        for (int i = 0; i < 80 && at < 0; i++) begin
            if (mem_finish) at = cyc;
            else tick();
        end
        check(tag, at, exp_fin);
        if (at >= 0) tick();
        write_enable = 1'b0;
        read_enable  = 1'b0;
        check({tag, "_one_pulse"}, mem_finish, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;

        do_reset();
        check("rst_pos",    drum_pos,   0);
        check("rst_phase",  drum_phase, 0);
        check("rst_busy",   busy,       0);
        check("rst_finish", mem_finish, 0);
        check("rst_rdata",  read_data,  0);

        // Aligned write to addr 3, then read it back.
        write_enable = 1'b1;
        addr         = 4'd3;
        write_data   = 31'h12345678;
        tick();
        check("wr3_busy_seek", busy, 1);
        req("wr3_finish", 1, 0, 4'd3, 31'h12345678, pick(8, 2));
        check("wr3_busy_idle", busy, 0);
        check("wr3_rotor_pos", drum_pos, pick(4, 1));
        check("wr3_rotor_phase", drum_phase, 1);
        req("rd3_finish", 0, 1, 4'd3, '0, pick(40, 5));
        check("rd3_data", read_data, 31'h12345678);
        repeat (5) tick();
        check("rd3_data_held", read_data, 31'h12345678);

        // Just-missed versus just-caught address 0.
        do_reset();
        tick();
        tick();
        req("miss0_finish", 0, 1, 4'd0, '0, pick(34, 4));
        do_reset();
        req("hit0_finish", 0, 1, 4'd0, '0, pick(2, 2));

        do_reset();
        repeat (4) tick();
        req("rd15_finish", 0, 1, 4'd15, '0, pick(32, 6));

        // Preload known words at addresses 6 and 9.
        do_reset();
        req("pre6_finish", 1, 0, 4'd6, 31'h0ABCDEF, pick(14, 2));
        req("pre9_finish", 1, 0, 4'd9, 31'h55, pick(20, 5));

        // Back-to-back write then read, enable still high during DONE.
        do_reset();
        req("b2b_wr_finish", 1, 0, 4'd5, 31'h5555, pick(12, 2));
        check("b2b_no_spawn", busy, 0);
        req("b2b_rd_finish", 0, 1, 4'd6, '0, pick(46, 5));
        check("b2b_rd_data", read_data, 31'h0ABCDEF);

        // Reset during SEEK aborts the write to addr 9.
        do_reset();
        write_enable = 1'b1;
        addr         = 4'd9;
        write_data   = 31'h7;
        repeat (pick(5, 1)) tick();
        check("abort_busy_seek", busy, 1);
        reset        = 1'b1;
        write_enable = 1'b0;
        tick();
        reset = 1'b0;
        cyc   = 0;
        check("abort_pos",    drum_pos,   0);
        check("abort_phase",  drum_phase, 0);
        check("abort_busy",   busy,       0);
        check("abort_finish", mem_finish, 0);
        req("abort_rd9_finish", 0, 1, 4'd9, '0, pick(20, 2));
        check("abort_rd9_data", read_data, 31'h55);

        // Simultaneous read+write: write wins, read_data untouched.
        req("rdwr2_finish", 1, 1, 4'd2, 31'h222, pick(38, 5));
        check("rdwr2_rdata_kept", read_data, 31'h55);
        req("rd2_finish", 0, 1, 4'd2, '0, pick(70, 8));
        check("rd2_data", read_data, 31'h222);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
